// File: rtl/rv_xocc_cmd_rsp_queue.sv
// Command/response queue between the RISC-V control core and the DSA rv_xocc interface.
// Three CPU words are assembled into one 96-bit command; DSA responses are buffered for the CPU.
module rv_xocc_cmd_rsp_queue #(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic        axi_aclk,
    input  logic        axi_areset,
    input  logic        cpu_cmd_wr_en,
    input  logic [31:0] cpu_cmd_wdata,
    input  logic        cpu_cmd_abort,
    output logic        cpu_cmd_full,
    input  logic        cpu_rsp_rd_en,
    output logic [31:0] cpu_rsp_rdata,
    output logic        cpu_rsp_empty,
    output logic [95:0] rv_xocc_cmd_buffer,
    output logic        rv_xocc_cmd_empty,
    input  logic        rv_xocc_cmd_rd_en,
    input  logic        rv_xocc_rsp_wr_en,
    input  logic [31:0] rv_xocc_rsp_buffer,
    output logic        rv_xocc_rsp_full,
    output logic [4:0]  cmd_count,
    output logic [4:0]  rsp_count,
    output logic [3:0]  err_flags
);

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned CMD_W     = 96;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned CMD_PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int unsigned RSP_PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [CMD_W-1:0]     cmd_mem [CMD_DEPTH];
    logic [WORD_W-1:0]    rsp_mem [RSP_DEPTH];

    logic [CMD_PTR_W-1:0] cmd_wr_ptr_q, cmd_wr_ptr_d, cmd_rd_ptr_q, cmd_rd_ptr_d;
    logic [RSP_PTR_W-1:0] rsp_wr_ptr_q, rsp_wr_ptr_d, rsp_rd_ptr_q, rsp_rd_ptr_d;
    logic [CNT_W-1:0]     cmd_cnt_q, cmd_cnt_d, rsp_cnt_q, rsp_cnt_d;
    logic [1:0]           beat_q, beat_d;
    logic [WORD_W-1:0]    stage0_q, stage0_d, stage1_q, stage1_d;
    logic [3:0]           err_q, err_d;

    logic cmd_full, cmd_empty, rsp_full, rsp_empty;
    logic cmd_wr_ok, cmd_commit, cmd_pop, rsp_push, rsp_pop;
    logic cmd_over, cmd_under, rsp_over, rsp_under;

    // Status decoded from registered occupancy only
    assign cmd_full  = (cmd_cnt_q == CNT_W'(CMD_DEPTH));
    assign cmd_empty = (cmd_cnt_q == '0);
    assign rsp_full  = (rsp_cnt_q == CNT_W'(RSP_DEPTH));
    assign rsp_empty = (rsp_cnt_q == '0);

    // Abort takes priority over a same-cycle write, which is then silently dropped
    assign cmd_wr_ok  = cpu_cmd_wr_en & ~cpu_cmd_abort & ~cmd_full;
    assign cmd_over   = cpu_cmd_wr_en & ~cpu_cmd_abort & cmd_full;
    assign cmd_commit = cmd_wr_ok & (beat_q == 2'd2);
    assign cmd_pop    = rv_xocc_cmd_rd_en & ~cmd_empty;
    assign cmd_under  = rv_xocc_cmd_rd_en & cmd_empty;

    assign rsp_push  = rv_xocc_rsp_wr_en & ~rsp_full;
    assign rsp_over  = rv_xocc_rsp_wr_en & rsp_full;
    assign rsp_pop   = cpu_rsp_rd_en & ~rsp_empty;
    assign rsp_under = cpu_rsp_rd_en & rsp_empty;

    always_comb begin
        beat_d       = beat_q;
        stage0_d     = stage0_q;
        stage1_d     = stage1_q;
        cmd_wr_ptr_d = cmd_wr_ptr_q;
        cmd_rd_ptr_d = cmd_rd_ptr_q;
        rsp_wr_ptr_d = rsp_wr_ptr_q;
        rsp_rd_ptr_d = rsp_rd_ptr_q;
        cmd_cnt_d    = cmd_cnt_q + CNT_W'(cmd_commit) - CNT_W'(cmd_pop);
        rsp_cnt_d    = rsp_cnt_q + CNT_W'(rsp_push) - CNT_W'(rsp_pop);
        err_d        = err_q | {rsp_under, rsp_over, cmd_under, cmd_over};

        if (cpu_cmd_abort) begin
            beat_d   = 2'd0;
            stage0_d = '0;
            stage1_d = '0;
        end else if (cmd_wr_ok) begin
            unique case (beat_q)
                2'd0:    begin stage0_d = cpu_cmd_wdata; beat_d = 2'd1; end
                2'd1:    begin stage1_d = cpu_cmd_wdata; beat_d = 2'd2; end
                default: beat_d = 2'd0;
            endcase
        end

        if (cmd_commit) cmd_wr_ptr_d = cmd_wr_ptr_q + CMD_PTR_W'(1);
        if (cmd_pop)    cmd_rd_ptr_d = cmd_rd_ptr_q + CMD_PTR_W'(1);
        if (rsp_push)   rsp_wr_ptr_d = rsp_wr_ptr_q + RSP_PTR_W'(1);
        if (rsp_pop)    rsp_rd_ptr_d = rsp_rd_ptr_q + RSP_PTR_W'(1);
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            beat_q       <= 2'd0;
            stage0_q     <= '0;
            stage1_q     <= '0;
            cmd_wr_ptr_q <= '0;
            cmd_rd_ptr_q <= '0;
            rsp_wr_ptr_q <= '0;
            rsp_rd_ptr_q <= '0;
            cmd_cnt_q    <= '0;
            rsp_cnt_q    <= '0;
            err_q        <= '0;
        end else begin
            beat_q       <= beat_d;
            stage0_q     <= stage0_d;
            stage1_q     <= stage1_d;
            cmd_wr_ptr_q <= cmd_wr_ptr_d;
            cmd_rd_ptr_q <= cmd_rd_ptr_d;
            rsp_wr_ptr_q <= rsp_wr_ptr_d;
            rsp_rd_ptr_q <= rsp_rd_ptr_d;
            cmd_cnt_q    <= cmd_cnt_d;
            rsp_cnt_q    <= rsp_cnt_d;
            err_q        <= err_d;
        end
    end

    // Storage needs no reset: heads are masked to zero whenever a FIFO is empty
    always_ff @(posedge axi_aclk) begin
        if (cmd_commit) cmd_mem[cmd_wr_ptr_q] <= {cpu_cmd_wdata, stage1_q, stage0_q};
        if (rsp_push)   rsp_mem[rsp_wr_ptr_q] <= rv_xocc_rsp_buffer;
    end

    assign cpu_cmd_full       = cmd_full;
    assign rv_xocc_cmd_empty  = cmd_empty;
    assign rv_xocc_cmd_buffer = cmd_empty ? '0 : cmd_mem[cmd_rd_ptr_q];
    assign rv_xocc_rsp_full   = rsp_full;
    assign cpu_rsp_empty      = rsp_empty;
    assign cpu_rsp_rdata      = rsp_empty ? '0 : rsp_mem[rsp_rd_ptr_q];
    assign cmd_count          = cmd_cnt_q;
    assign rsp_count          = rsp_cnt_q;
    assign err_flags          = err_q;

endmodule

// File: tb/tb_rv_xocc_cmd_rsp_queue.sv
// Bench for rv_xocc_cmd_rsp_queue: directed scenarios plus random traffic against a queue-based model.
module tb_rv_xocc_cmd_rsp_queue;

    localparam int CMD_DEPTH = 4;
    localparam int RSP_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_cmd_wr_en, cpu_cmd_abort, cpu_rsp_rd_en;
    logic [31:0] cpu_cmd_wdata;
    logic        cpu_cmd_full, cpu_rsp_empty;
    logic [31:0] cpu_rsp_rdata;
    logic [95:0] rv_xocc_cmd_buffer;
    logic        rv_xocc_cmd_empty, rv_xocc_cmd_rd_en, rv_xocc_rsp_wr_en, rv_xocc_rsp_full;
    logic [31:0] rv_xocc_rsp_buffer;
    logic [4:0]  cmd_count, rsp_count;
    logic [3:0]  err_flags;

    int checks = 0;
    int errors = 0;

    logic [95:0] m_cmd[$];
    logic [31:0] m_rsp[$];
    logic [31:0] m_stage[3];
    int          m_beat;
    logic [3:0]  m_err;

    rv_xocc_cmd_rsp_queue #(.CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH)) dut (
        .axi_aclk           (clk),
        .axi_areset         (rst),
        .cpu_cmd_wr_en      (cpu_cmd_wr_en),
        .cpu_cmd_wdata      (cpu_cmd_wdata),
        .cpu_cmd_abort      (cpu_cmd_abort),
        .cpu_cmd_full       (cpu_cmd_full),
        .cpu_rsp_rd_en      (cpu_rsp_rd_en),
        .cpu_rsp_rdata      (cpu_rsp_rdata),
        .cpu_rsp_empty      (cpu_rsp_empty),
        .rv_xocc_cmd_buffer (rv_xocc_cmd_buffer),
        .rv_xocc_cmd_empty  (rv_xocc_cmd_empty),
        .rv_xocc_cmd_rd_en  (rv_xocc_cmd_rd_en),
        .rv_xocc_rsp_wr_en  (rv_xocc_rsp_wr_en),
        .rv_xocc_rsp_buffer (rv_xocc_rsp_buffer),
        .rv_xocc_rsp_full   (rv_xocc_rsp_full),
        .cmd_count          (cmd_count),
        .rsp_count          (rsp_count),
        .err_flags          (err_flags)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] exp_cmd_head();
        if (m_cmd.size() == 0) return 96'h0;
        return m_cmd[0];
    endfunction

    function automatic logic [31:0] exp_rsp_head();
        if (m_rsp.size() == 0) return 32'h0;
        return m_rsp[0];
    endfunction

    task automatic model_reset();
        m_cmd.delete();
        m_rsp.delete();
        m_beat = 0;
        m_err  = 4'h0;
    endtask

    task automatic idle();
        cpu_cmd_wr_en      = 1'b0;
        cpu_cmd_wdata      = 32'h0;
        cpu_cmd_abort      = 1'b0;
        cpu_rsp_rd_en      = 1'b0;
        rv_xocc_cmd_rd_en  = 1'b0;
        rv_xocc_rsp_wr_en  = 1'b0;
        rv_xocc_rsp_buffer = 32'h0;
    endtask

    // Apply the behavioural rules to the pre-edge state, then clock once and settle
    task automatic step();
        int csz;
        int rsz;
        csz = m_cmd.size();
        rsz = m_rsp.size();
        if (rv_xocc_cmd_rd_en) begin
            if (csz == 0) m_err[1] = 1'b1;
            else void'(m_cmd.pop_front());
        end
        if (cpu_cmd_abort) begin
            m_beat = 0;
        end else if (cpu_cmd_wr_en) begin
            if (csz == CMD_DEPTH) m_err[0] = 1'b1;
            else begin
                m_stage[m_beat] = cpu_cmd_wdata;
                m_beat++;
                if (m_beat == 3) begin
                    m_cmd.push_back({m_stage[2], m_stage[1], m_stage[0]});
                    m_beat = 0;
                end
            end
        end
        if (cpu_rsp_rd_en) begin
            if (rsz == 0) m_err[3] = 1'b1;
            else void'(m_rsp.pop_front());
        end
        if (rv_xocc_rsp_wr_en) begin
            if (rsz == RSP_DEPTH) m_err[2] = 1'b1;
            else m_rsp.push_back(rv_xocc_rsp_buffer);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [31:0] w);
        cpu_cmd_wr_en = 1'b1;
        cpu_cmd_wdata = w;
        step();
        cpu_cmd_wr_en = 1'b0;
    endtask

    task automatic pop_cmd();
        rv_xocc_cmd_rd_en = 1'b1;
        step();
        rv_xocc_cmd_rd_en = 1'b0;
    endtask

    task automatic push_rsp(input logic [31:0] w);
        rv_xocc_rsp_wr_en  = 1'b1;
        rv_xocc_rsp_buffer = w;
        step();
        rv_xocc_rsp_wr_en  = 1'b0;
    endtask

    task automatic pop_rsp();
        cpu_rsp_rd_en = 1'b1;
        step();
        cpu_rsp_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        model_reset();
        #1;
        checks++;
        if ({cpu_cmd_full, cpu_rsp_empty, rv_xocc_cmd_empty, rv_xocc_rsp_full} !== 4'b0110) begin
            errors++;
            $display("FAIL reset_status: got %b exp 0110",
                     {cpu_cmd_full, cpu_rsp_empty, rv_xocc_cmd_empty, rv_xocc_rsp_full});
        end
        checks++;
        if ({cmd_count, rsp_count, err_flags} !== 14'h0) begin
            errors++;
            $display("FAIL reset_counts: got cmd=%0d rsp=%0d err=%b", cmd_count, rsp_count, err_flags);
        end
        checks++;
        if (rv_xocc_cmd_buffer !== 96'h0 || cpu_rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got cmd=%h rsp=%h exp 0", rv_xocc_cmd_buffer, cpu_rsp_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_cmd_basic();
        wr_word(32'h11111111);
        wr_word(32'h22222222);
        checks++;
        if (rv_xocc_cmd_empty !== 1'b1) begin
            errors++;
            $display("FAIL partial_not_visible: got empty=%b exp 1", rv_xocc_cmd_empty);
        end
        wr_word(32'h33333333);
        checks++;
        if (rv_xocc_cmd_empty !== 1'b0 || cmd_count !== 5'd1 ||
            rv_xocc_cmd_buffer !== 96'h333333332222222211111111) begin
            errors++;
            $display("FAIL cmd_basic: got empty=%b cnt=%0d buf=%h exp 0/1/333333332222222211111111",
                     rv_xocc_cmd_empty, cmd_count, rv_xocc_cmd_buffer);
        end
        pop_cmd();
        checks++;
        if (rv_xocc_cmd_empty !== 1'b1 || rv_xocc_cmd_buffer !== 96'h0 || cmd_count !== 5'd0) begin
            errors++;
            $display("FAIL cmd_basic_pop: got empty=%b buf=%h cnt=%0d", rv_xocc_cmd_empty,
                     rv_xocc_cmd_buffer, cmd_count);
        end
    endtask

    task automatic test_cmd_full();
        for (int i = 0; i < 12; i++) wr_word($urandom);
        checks++;
        if (cpu_cmd_full !== 1'b1 || cmd_count !== 5'd4) begin
            errors++;
            $display("FAIL cmd_full: got full=%b cnt=%0d exp 1/4", cpu_cmd_full, cmd_count);
        end
        wr_word(32'hBAD0BAD0);
        checks++;
        if (err_flags[0] !== 1'b1 || cmd_count !== 5'd4) begin
            errors++;
            $display("FAIL cmd_overflow: got err=%b cnt=%0d exp err[0]=1 cnt=4", err_flags, cmd_count);
        end
        pop_cmd();
        for (int i = 0; i < 3; i++) wr_word($urandom);
        checks++;
        if (cmd_count !== 5'd4 || cpu_cmd_full !== 1'b1) begin
            errors++;
            $display("FAIL cmd_refill: got cnt=%0d full=%b exp 4/1", cmd_count, cpu_cmd_full);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rv_xocc_cmd_buffer !== exp_cmd_head()) begin
                errors++;
                $display("FAIL cmd_drain_%0d: got %h exp %h", i, rv_xocc_cmd_buffer, exp_cmd_head());
            end
            pop_cmd();
        end
        checks++;
        if (rv_xocc_cmd_empty !== 1'b1 || err_flags !== m_err) begin
            errors++;
            $display("FAIL cmd_drained: got empty=%b err=%b exp 1/%b", rv_xocc_cmd_empty, err_flags, m_err);
        end
    endtask

    task automatic test_abort();
        wr_word(32'h1);
        wr_word(32'h2);
        cpu_cmd_abort = 1'b1;
        step();
        cpu_cmd_abort = 1'b0;
        wr_word(32'hA);
        // Abort with a concurrent write: the write must be dropped without error
        cpu_cmd_abort = 1'b1;
        cpu_cmd_wr_en = 1'b1;
        cpu_cmd_wdata = 32'hEEEE;
        step();
        cpu_cmd_abort = 1'b0;
        cpu_cmd_wr_en = 1'b0;
        checks++;
        if (err_flags !== m_err || rv_xocc_cmd_empty !== 1'b1) begin
            errors++;
            $display("FAIL abort_with_write: got err=%b empty=%b exp %b/1", err_flags, rv_xocc_cmd_empty, m_err);
        end
        wr_word(32'hA);
        wr_word(32'hB);
        wr_word(32'hC);
        checks++;
        if (rv_xocc_cmd_buffer !== 96'h0000000C0000000B0000000A || cmd_count !== 5'd1) begin
            errors++;
            $display("FAIL abort_head: got %h cnt=%0d exp 0000000C0000000B0000000A/1",
                     rv_xocc_cmd_buffer, cmd_count);
        end
        pop_cmd();
    endtask

    task automatic test_rsp();
        logic [31:0] exp_w;
        for (int i = 1; i <= 5; i++) begin
            push_rsp(32'hDEAD0000 + 32'(i));
            if (i == 4) begin
                checks++;
                if (rv_xocc_rsp_full !== 1'b1 || rsp_count !== 5'd4 || err_flags[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL rsp_full: got full=%b cnt=%0d err=%b", rv_xocc_rsp_full, rsp_count, err_flags);
                end
            end
        end
        checks++;
        if (err_flags[2] !== 1'b1 || rsp_count !== 5'd4) begin
            errors++;
            $display("FAIL rsp_overflow: got err=%b cnt=%0d exp err[2]=1 cnt=4", err_flags, rsp_count);
        end
        for (int i = 1; i <= 4; i++) begin
            exp_w = 32'hDEAD0000 + 32'(i);
            checks++;
            if (cpu_rsp_rdata !== exp_w) begin
                errors++;
                $display("FAIL rsp_pop_%0d: got %h exp %h", i, cpu_rsp_rdata, exp_w);
            end
            pop_rsp();
        end
        checks++;
        if (err_flags[3] !== 1'b0 || cpu_rsp_empty !== 1'b1) begin
            errors++;
            $display("FAIL rsp_drained: got err=%b empty=%b exp err[3]=0 empty=1", err_flags, cpu_rsp_empty);
        end
        pop_rsp();
        checks++;
        if (err_flags[3] !== 1'b1 || rsp_count !== 5'd0) begin
            errors++;
            $display("FAIL rsp_underflow: got err=%b cnt=%0d exp err[3]=1 cnt=0", err_flags, rsp_count);
        end
        // Push+pop while empty: push lands
        cpu_rsp_rd_en = 1'b1;
        rv_xocc_rsp_wr_en = 1'b1;
        rv_xocc_rsp_buffer = 32'hCAFE0001;
        step();
        checks++;
        if (rsp_count !== 5'd1 || cpu_rsp_rdata !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL rsp_pushpop_empty: got cnt=%0d data=%h exp 1/CAFE0001", rsp_count, cpu_rsp_rdata);
        end
        cpu_rsp_rd_en = 1'b0;
        rv_xocc_rsp_wr_en = 1'b0;
        for (int i = 2; i <= 4; i++) push_rsp(32'hCAFE0000 + 32'(i));
        // Push+pop while full: pop proceeds, push dropped
        cpu_rsp_rd_en = 1'b1;
        rv_xocc_rsp_wr_en = 1'b1;
        rv_xocc_rsp_buffer = 32'hCAFE0099;
        step();
        cpu_rsp_rd_en = 1'b0;
        rv_xocc_rsp_wr_en = 1'b0;
        checks++;
        if (rsp_count !== 5'd3 || cpu_rsp_rdata !== 32'hCAFE0002 || m_rsp.size() != 3) begin
            errors++;
            $display("FAIL rsp_pushpop_full: got cnt=%0d data=%h exp 3/CAFE0002", rsp_count, cpu_rsp_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cpu_rsp_rdata !== exp_rsp_head()) begin
                errors++;
                $display("FAIL rsp_tail_%0d: got %h exp %h", i, cpu_rsp_rdata, exp_rsp_head());
            end
            pop_rsp();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) wr_word($urandom);
        cpu_cmd_wr_en = 1'b1;
        cpu_cmd_wdata = $urandom;
        rv_xocc_cmd_rd_en = 1'b1;
        step();
        cpu_cmd_wr_en = 1'b0;
        rv_xocc_cmd_rd_en = 1'b0;
        checks++;
        if (cmd_count !== 5'd2 || m_cmd.size() != 2) begin
            errors++;
            $display("FAIL commit_and_pop: got cnt=%0d exp 2", cmd_count);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rv_xocc_cmd_buffer !== exp_cmd_head()) begin
                errors++;
                $display("FAIL b2b_order_%0d: got %h exp %h", i, rv_xocc_cmd_buffer, exp_cmd_head());
            end
            pop_cmd();
        end
        checks++;
        if (err_flags[1] !== 1'b0) begin
            errors++;
            $display("FAIL cmd_underflow_early: got err=%b exp err[1]=0", err_flags);
        end
        pop_cmd();
        checks++;
        if (err_flags[1] !== 1'b1 || cmd_count !== 5'd0 || rv_xocc_cmd_empty !== 1'b1) begin
            errors++;
            $display("FAIL cmd_underflow: got err=%b cnt=%0d empty=%b exp err[1]=1 cnt=0 empty=1",
                     err_flags, cmd_count, rv_xocc_cmd_empty);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) wr_word($urandom);
        push_rsp($urandom);
        push_rsp($urandom);
        wr_word(32'h77777777);
        #2;
        rst = 1'b1;
        #1;
        // Still before the next rising edge
        checks++;
        if ({cpu_cmd_full, cpu_rsp_empty, rv_xocc_cmd_empty, rv_xocc_rsp_full} !== 4'b0110 ||
            {cmd_count, rsp_count, err_flags} !== 14'h0 ||
            rv_xocc_cmd_buffer !== 96'h0 || cpu_rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got status=%b cmd=%0d rsp=%0d err=%b buf=%h rdata=%h",
                     {cpu_cmd_full, cpu_rsp_empty, rv_xocc_cmd_empty, rv_xocc_rsp_full},
                     cmd_count, rsp_count, err_flags, rv_xocc_cmd_buffer, cpu_rsp_rdata);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wr_word(32'h44444444);
        wr_word(32'h55555555);
        wr_word(32'h66666666);
        checks++;
        if (rv_xocc_cmd_buffer !== 96'h666666665555555544444444 || cmd_count !== 5'd1) begin
            errors++;
            $display("FAIL post_reset_cmd: got %h cnt=%0d exp 666666665555555544444444/1",
                     rv_xocc_cmd_buffer, cmd_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cpu_cmd_wr_en      = ($urandom_range(0, 99) < 55);
            cpu_cmd_wdata      = $urandom;
            cpu_cmd_abort      = ($urandom_range(0, 99) < 4);
            rv_xocc_cmd_rd_en  = ($urandom_range(0, 99) < 25);
            rv_xocc_rsp_wr_en  = ($urandom_range(0, 99) < 50);
            rv_xocc_rsp_buffer = $urandom;
            cpu_rsp_rd_en      = ($urandom_range(0, 99) < 45);
            step();
            checks++;
            if (cpu_cmd_full !== (m_cmd.size() == CMD_DEPTH) ||
                rv_xocc_cmd_empty !== (m_cmd.size() == 0) || cmd_count !== 5'(m_cmd.size())) begin
                errors++;
                $display("FAIL rnd_cmd_status@%0d: got full=%b empty=%b cnt=%0d exp cnt=%0d",
                         n, cpu_cmd_full, rv_xocc_cmd_empty, cmd_count, m_cmd.size());
            end
            checks++;
            if (rv_xocc_cmd_buffer !== exp_cmd_head()) begin
                errors++;
                $display("FAIL rnd_cmd_head@%0d: got %h exp %h", n, rv_xocc_cmd_buffer, exp_cmd_head());
            end
            checks++;
            if (rv_xocc_rsp_full !== (m_rsp.size() == RSP_DEPTH) || cpu_rsp_empty !== (m_rsp.size() == 0) ||
                rsp_count !== 5'(m_rsp.size()) || cpu_rsp_rdata !== exp_rsp_head()) begin
                errors++;
                $display("FAIL rnd_rsp@%0d: got full=%b empty=%b cnt=%0d data=%h exp cnt=%0d data=%h",
                         n, rv_xocc_rsp_full, cpu_rsp_empty, rsp_count, cpu_rsp_rdata,
                         m_rsp.size(), exp_rsp_head());
            end
            checks++;
            if (err_flags !== m_err) begin
                errors++;
                $display("FAIL rnd_err@%0d: got %b exp %b", n, err_flags, m_err);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_cmd_basic();
        test_cmd_full();
        test_abort();
        test_rsp();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
